// File: rtl/an_corrector_n37.sv
// AN-code (A = 37) single-error corrector: maps a decoder's residue to a signed
// power-of-two error, repairs the quotient and range-checks the result.
module an_corrector_n37 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [12:0] q,
    input  logic [5:0]  r,
    input  logic        error,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [12:0] data,
    output logic [1:0]  status,
    output logic [15:0] corr_cnt,
    output logic [15:0] fail_cnt,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1; valid never waits on ready, and a held output does not change.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_ADD    = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    localparam logic [1:0] ST_CLEAN = 2'b00;
    localparam logic [1:0] ST_CORR  = 2'b01;
    localparam logic [1:0] ST_FAIL  = 2'b10;

    state_t             r_state;
    state_t             w_next;
    logic [12:0]        r_q;
    logic [5:0]         r_r;
    logic               r_err;
    logic signed [14:0] r_k;
    logic               r_zero;
    logic               r_bad;
    logic               r_out_valid;
    logic [12:0]        r_data;
    logic [1:0]         r_status;
    logic [15:0]        r_corr_cnt;
    logic [15:0]        r_fail_cnt;
    logic signed [14:0] w_k;
    logic signed [14:0] w_s;
    logic [12:0]        w_data;
    logic [1:0]         w_status;
    logic               w_accept;
    logic               w_release;

    // k = (r - e) / 37 where e = +/-2^i; r = 1..36 each map to exactly one i.
    always_comb begin
        w_k = 15'sd0;
        case (r_r)
            6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32: w_k = 15'sd0;
            6'd27: w_k = -15'sd1;
            6'd17: w_k = -15'sd3;
            6'd34: w_k = -15'sd6;
            6'd31: w_k = -15'sd13;
            6'd25: w_k = -15'sd27;
            6'd13: w_k = -15'sd55;
            6'd26: w_k = -15'sd110;
            6'd15: w_k = -15'sd221;
            6'd30: w_k = -15'sd442;
            6'd23: w_k = -15'sd885;
            6'd9:  w_k = -15'sd1771;
            6'd18: w_k = -15'sd3542;
            6'd36, 6'd35, 6'd33, 6'd29, 6'd21, 6'd5: w_k = 15'sd1;
            6'd10: w_k = 15'sd2;
            6'd20: w_k = 15'sd4;
            6'd3:  w_k = 15'sd7;
            6'd6:  w_k = 15'sd14;
            6'd12: w_k = 15'sd28;
            6'd24: w_k = 15'sd56;
            6'd11: w_k = 15'sd111;
            6'd22: w_k = 15'sd222;
            6'd7:  w_k = 15'sd443;
            6'd14: w_k = 15'sd886;
            6'd28: w_k = 15'sd1772;
            6'd19: w_k = 15'sd3543;
            default: w_k = 15'sd0;
        endcase
    end

    assign w_s = $signed({2'b00, r_q}) + r_k;

    always_comb begin
        w_data   = 13'd0;
        w_status = ST_FAIL;
        if (r_bad) begin
            w_data   = 13'd0;
            w_status = ST_FAIL;
        end else if (r_zero) begin
            w_data   = r_q;
            w_status = ST_CLEAN;
        end else if (!w_s[14] && (w_s <= 15'sd7084)) begin
            w_data   = w_s[12:0];
            w_status = ST_CORR;
        end
    end

    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign w_release = r_out_valid && out_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (in_valid) w_next = S_LOOKUP;
            S_LOOKUP: w_next = S_ADD;
            S_ADD:    w_next = S_HOLD;
            S_HOLD:   if (w_release) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_q         <= 13'd0;
            r_r         <= 6'd0;
            r_err       <= 1'b0;
            r_k         <= 15'sd0;
            r_zero      <= 1'b0;
            r_bad       <= 1'b0;
            r_out_valid <= 1'b0;
            r_data      <= 13'd0;
            r_status    <= ST_CLEAN;
            r_corr_cnt  <= 16'd0;
            r_fail_cnt  <= 16'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_q   <= q;
                r_r   <= r;
                r_err <= error;
            end
            if (r_state == S_LOOKUP) begin
                r_k    <= w_k;
                r_zero <= (r_r == 6'd0);
                r_bad  <= (r_r > 6'd36) || (r_err != (r_r != 6'd0));
            end
            if (r_state == S_ADD) begin
                r_data   <= w_data;
                r_status <= w_status;
                if (w_status == ST_CORR && r_corr_cnt != 16'hFFFF)
                    r_corr_cnt <= r_corr_cnt + 16'd1;
                if (w_status == ST_FAIL && r_fail_cnt != 16'hFFFF)
                    r_fail_cnt <= r_fail_cnt + 16'd1;
            end
            // out_valid rises one cycle into HOLD, after data/status have settled.
            if (r_state == S_HOLD && !r_out_valid)
                r_out_valid <= 1'b1;
            else if (w_release)
                r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign data      = r_data;
    assign status    = r_status;
    assign corr_cnt  = r_corr_cnt;
    assign fail_cnt  = r_fail_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_an_corrector_n37.sv
// Directed bench for an_corrector_n37: hand-computed correction vectors,
// back-pressure, reset mid-word and counter saturation.
module tb_an_corrector_n37;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] q;
    logic [5:0]  r;
    logic        error;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] data;
    logic [1:0]  status;
    logic [15:0] corr_cnt;
    logic [15:0] fail_cnt;
    logic [1:0]  dbg_state;

    int          n_cmp;
    int          n_mis;
    logic [15:0] exp_corr;
    logic [15:0] exp_fail;

    an_corrector_n37 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .r         (r),
        .error     (error),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data      (data),
        .status    (status),
        .corr_cnt  (corr_cnt),
        .fail_cnt  (fail_cnt),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_word(input string tag, input logic [12:0] wq, input logic [5:0] wr,
                            input logic we, input logic [12:0] ed, input logic [1:0] es);
        int lat;
        @(negedge clk);
        check({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        q        = wq;
        r        = wr;
        error    = we;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (es == 2'b01 && exp_corr != 16'hFFFF) exp_corr++;
        if (es == 2'b10 && exp_fail != 16'hFFFF) exp_fail++;
        check({tag, "_latency"}, lat, 3);
        check({tag, "_data"}, data, ed);
        check({tag, "_status"}, status, es);
        check({tag, "_corr_cnt"}, corr_cnt, exp_corr);
        check({tag, "_fail_cnt"}, fail_cnt, exp_fail);
        @(posedge clk);
        #1;
        check({tag, "_valid_drop"}, out_valid, 0);
    endtask

    initial begin
        n_cmp     = 0;
        n_mis     = 0;
        exp_corr  = 16'd0;
        exp_fail  = 16'd0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        q         = 13'd0;
        r         = 6'd0;
        error     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_data", data, 0);
        check("rst_status", status, 0);
        check("rst_corr", corr_cnt, 0);
        check("rst_fail", fail_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_state", dbg_state, 0);
        @(negedge clk);
        rst = 1'b0;

        // codeword = 37*data + e; k = (r - e)/37 computed by hand per vector
        run_word("clean100",   13'd100,  6'd0,  1'b0, 13'd100,  2'b00);
        run_word("cw3716",     13'd100,  6'd16, 1'b1, 13'd100,  2'b01);
        run_word("cw2676",     13'd72,   6'd12, 1'b1, 13'd100,  2'b01);
        run_word("cw262143",   13'd7084, 6'd35, 1'b1, 13'd0,    2'b10);
        run_word("r19_k3543",  13'd0,    6'd19, 1'b1, 13'd3543, 2'b01);
        run_word("r18_neg",    13'd3000, 6'd18, 1'b1, 13'd0,    2'b10);
        run_word("r18_zero",   13'd3542, 6'd18, 1'b1, 13'd0,    2'b01);
        run_word("r1_max",     13'd7084, 6'd1,  1'b1, 13'd7084, 2'b01);
        run_word("r36_max",    13'd7083, 6'd36, 1'b1, 13'd7084, 2'b01);
        run_word("r40_bad",    13'd50,   6'd40, 1'b1, 13'd0,    2'b10);
        run_word("err_lo",     13'd50,   6'd5,  1'b0, 13'd0,    2'b10);
        run_word("err_hi",     13'd50,   6'd0,  1'b1, 13'd0,    2'b10);

        // back-pressure: hold for 5 cycles while a competing input is offered
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        q        = 13'd200;
        r        = 6'd0;
        error    = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        begin
            int lat;
            lat = 0;
            while (!out_valid && lat < 10) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check("hold_latency", lat, 3);
        end
        @(negedge clk);
        in_valid = 1'b1;
        q        = 13'd555;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", out_valid, 1);
            check("hold_data", data, 200);
            check("hold_status", status, 0);
            check("hold_in_ready", in_ready, 0);
            check("hold_state", dbg_state, 3);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        run_word("after_hold", 13'd666, 6'd0, 1'b0, 13'd666, 2'b00);

        // reset while the word is in ADD: abandoned and uncounted
        @(negedge clk);
        in_valid = 1'b1;
        q        = 13'd5;
        r        = 6'd16;
        error    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid_state_add", dbg_state, 2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_corr = 16'd0;
        exp_fail = 16'd0;
        check("midrst_valid", out_valid, 0);
        check("midrst_corr", corr_cnt, 0);
        check("midrst_fail", fail_cnt, 0);
        check("midrst_state", dbg_state, 0);
        check("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_no_output", out_valid, 0);

        // saturation from a preloaded count
        @(negedge clk);
        dut.r_corr_cnt = 16'hFFFE;
        exp_corr       = 16'hFFFE;
        run_word("sat1", 13'd10, 6'd2,  1'b1, 13'd10, 2'b01);
        run_word("sat2", 13'd11, 6'd27, 1'b1, 13'd10, 2'b01);
        run_word("sat3", 13'd9,  6'd36, 1'b1, 13'd10, 2'b01);
        check("sat_final", corr_cnt, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/an_corrector_n37.md
AN_CORRECTOR_N37 -- requirements
Module: an_corrector_n37

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have: in_valid  input  1  upstream decoder result valid.
REQ-004 SHALL have: in_ready  output  1  block can accept a result.
REQ-005 SHALL have: q  input  13  decoder quotient.
REQ-006 SHALL have: r  input  6  decoder residue, 0..36.
REQ-007 SHALL have: error  input  1  decoder flag, r nonzero.
REQ-008 SHALL have: out_valid  output  1  corrected result valid.
REQ-009 SHALL have: out_ready  input  1  downstream accepts result.
REQ-010 SHALL have: data  output  13  corrected data word, 0..7084.
REQ-011 SHALL have: status  output  2  00 clean, 01 corrected, 10 uncorrectable, 11 unused.
REQ-012 SHALL have: corr_cnt  output  16  saturating count of corrected words.
REQ-013 SHALL have: fail_cnt  output  16  saturating count of uncorrectable words.

Function
REQ-014 SHALL implement FSM IDLE -> LOOKUP -> ADD -> HOLD -> IDLE; in_ready=1 only in IDLE.
REQ-015 SHALL register q, r, error on the clk edge where in_valid and in_ready are both 1, moving IDLE->LOOKUP.
REQ-016 SHALL, in LOOKUP, map r through a 36-entry constant table to signed error e = +2^i when r = 2^i mod 37, e = -2^i when r = 37 - (2^i mod 37), for i = 0..17; the table covers all of r = 1..36 uniquely.
REQ-017 SHALL store per entry the signed offset k = (r - e)/37, an exact integer (15-bit signed).
REQ-018 SHALL, in ADD, compute s = q + k as 15-bit signed, with no truncation before the range check.
REQ-019 SHALL classify: r=0 -> status 00, data=q; r in 1..36 and 0 <= s <= 7084 -> status 01, data=s[12:0]; otherwise -> status 10, data=0.
REQ-020 SHALL treat r > 36, or error disagreeing with (r != 0), as uncorrectable: status 10, data=0.
REQ-021 SHALL enter HOLD with out_valid=1; data and status SHALL be stable while out_valid=1 and out_ready=0.
REQ-022 SHALL leave HOLD to IDLE on the edge where out_valid=1 and out_ready=1; out_valid SHALL drop the next cycle.
REQ-023 SHALL assert out_valid exactly 3 cycles after the accepting edge when out_ready is held at 1 (accept edge N, out_valid high from edge N+3).
REQ-024 SHALL increment corr_cnt or fail_cnt once per word on the ADD->HOLD transition, saturating at 16'hFFFF with no wrap.
REQ-025 SHALL ignore in_valid outside IDLE; inputs presented then are neither captured nor dropped by this block.

Reset
REQ-026 SHALL, on rst=1 at a clk edge, enter IDLE and set out_valid=0, data=0, status=00, corr_cnt=0, fail_cnt=0, in_ready=1 from the next cycle.
REQ-027 SHALL abandon any in-flight word on reset mid-operation without counting it; rst SHALL take priority over every handshake.

Verification
REQ-028 SHALL cover: q=100, r=0, error=0 -> data=100, status=00, counters unchanged, out_valid 3 cycles after accept.
REQ-029 SHALL cover: codeword 3716 (q=100, r=16, e=+16, k=0) -> data=100, status=01, corr_cnt=1.
REQ-030 SHALL cover: codeword 2676 (q=72, r=12, e=-1024, k=28) -> data=100, status=01.
REQ-031 SHALL cover: codeword 262143 (q=7084, r=35, e=-2, s=7085) -> data=0, status=10, fail_cnt=1.
REQ-032 SHALL cover: out_ready held 0 for 5 cycles in HOLD -> out_valid, data, status stable, in_ready=0, and a new in_valid is not accepted; after release, accept resumes in IDLE.
REQ-033 SHALL cover: rst asserted in ADD -> next cycle out_valid=0, counters 0, state IDLE; corr_cnt preloaded near 16'hFFFF saturates at 16'hFFFF.
